alu_md_seq: RTL and testbench
=============================

# alu_md_seq

Registered, parametrised-width execute unit for the pipelined RISC-V core: the one-hot RV32I/RV64I ALU operations plus the M-extension multiply/divide group, behind a valid/ready handshake. Base operations complete in one cycle. Multiplies take two cycles. Divides and remainders use an iterative radix-2 divider. The block sits in the EX stage; the hazard unit stalls on `ready_o` and flushes it on branch mispredict.

## Interface
- `XLEN`, 32, datapath width (32 or 64)
- `SHAMT_W`, `$clog2(XLEN)`, shift-amount width (derived; not overridden)
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `valid_i`  in  1  operation offered
- `ready_o`  out  1  unit can accept this cycle
- `op_i`  in  19  one-hot operation select, indices in `alu_pkg`
- `op1_i`, `op2_i`  in  XLEN  operands
- `flush_i`  in  1  kill in-flight and held operation
- `valid_o`  out  1  result held
- `ready_i`  in  1  downstream consumes result
- `result_o`  out  XLEN  registered result
- `err_o`  out  1  qualifies `valid_o`: `op_i` was not exactly one-hot

## Operation
- `op_i` bit assignments:
  - 0..10: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND, SUB, SRA, LUI (LUI passes `op1_i`).
  - 11..18: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- Shifts use `op2_i[SHAMT_W-1:0]`. SLT/SLTU return zero-extended 1/0.
- Transfer occurs when `valid_i && ready_o`.
- `ready_o = (state==IDLE) && (!valid_o || ready_i) && !flush_i`.
- FSM states:
  - IDLE: base op, illegal op, or div fast-path goes to IDLE with `valid_o` set next cycle. MUL* goes to MUL. Other DIV*/REM* goes to DIV.
  - MUL: the product (2·XLEN bits, signedness per op) is registered. Next cycle selects the low/high half, then returns to IDLE with `valid_o`.
  - DIV: operands are converted to magnitudes, then XLEN iterations run, then the sign fix-up. Then returns to IDLE with `valid_o`.
- Divide fast-path, 1-cycle latency, no iteration:
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give `op1_i`.
  - Signed overflow (most-negative ÷ −1): DIV gives most-negative; REM gives 0.
- Illegal `op_i` (zero or more than one bit set): accepted, `result_o`=0, `err_o`=1, latency 1.
- Result hold: `valid_o`, `result_o`, `err_o` hold until `ready_i`. `valid_o` drops the cycle after consumption unless a new result is loaded in the same edge (back-to-back base ops reach full throughput).
- `flush_i` (synchronous): state goes to IDLE, `valid_o` goes to 0, and the divider is aborted. It overrides a same-cycle transfer, which is dropped.

## Timing
- Reset values: `valid_o`=0, `result_o`=0, `err_o`=0, state=IDLE.
- `ready_o` is 1 from the first edge after reset deasserts.
- Latency, counted as edges from transfer to `valid_o`:
  - base, illegal, div fast-path: 1
  - MUL*: 2
  - DIV*/REM*: XLEN+2
- While busy, `ready_o`=0 and `valid_i` is ignored.
- Reset asserted mid-divide aborts immediately, with no result.
- If `ready_i`=0 while `valid_o` is held, the next transfer is blocked, not overwritten.

## Configuration
- `ALU_MULDIV_EN` defined: behaviour as above.
- Not defined:
  - Ops 11..18 are treated as illegal (1 cycle, `result_o`=0, `err_o`=1).
  - No multiplier or divider logic is built.
  - FSM reduces to IDLE only.

## Structure
- `alu_pkg`:
  - `OP_W`=19
  - op index localparams
  - `md_state_t` enum (IDLE, MUL, DIV)
- Sub-module `alu_divider`: iterative unsigned restoring divider.
  - Ports: `start`, `abort`, `busy`, `done`, XLEN `quotient`/`remainder`.
  - Compiled only under `ALU_MULDIV_EN`.
- Top owns sign handling, fast-paths, output register and handshake.

## Test plan
- XLEN=32, ADD 0x7FFFFFFF+1, then SRA 0x80000000>>>4 back-to-back with `ready_i`=1 → 0x80000000, then 0xF8000000 on consecutive cycles.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0 at latency 2; MULHU of the same operands → 0xFFFFFFFE.
- DIV −7÷2 → 0xFFFFFFFD at latency 34, `ready_o` low throughout; REM of the same operands → 0xFFFFFFFF.
- DIVU 5÷0 → 0xFFFFFFFF at latency 1; DIV 0x80000000÷−1 → 0x80000000; REM of the same operands → 0.
- `op_i`=0b11 → `err_o`=1, `result_o`=0. `ready_i` held low 3 cycles → outputs stable, `ready_o`=0.
- `flush_i` at cycle 10 of DIV → `valid_o` never asserts, `ready_o`=1 next cycle. `rst_i` pulse mid-DIV → all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_md_seq execute unit.
// Op indices, the md FSM state type and a one-hot check helper.
package alu_pkg;

  localparam int OP_W = 19;

  localparam int OP_ADD    = 0;
  localparam int OP_SLL    = 1;
  localparam int OP_SLT    = 2;
  localparam int OP_SLTU   = 3;
  localparam int OP_XOR    = 4;
  localparam int OP_SRL    = 5;
  localparam int OP_OR     = 6;
  localparam int OP_AND    = 7;
  localparam int OP_SUB    = 8;
  localparam int OP_SRA    = 9;
  localparam int OP_LUI    = 10;
  localparam int OP_MUL    = 11;
  localparam int OP_MULH   = 12;
  localparam int OP_MULHSU = 13;
  localparam int OP_MULHU  = 14;
  localparam int OP_DIV    = 15;
  localparam int OP_DIVU   = 16;
  localparam int OP_REM    = 17;
  localparam int OP_REMU   = 18;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV
  } md_state_t;

  function automatic logic one_hot(input logic [OP_W-1:0] op);
    return (op != '0) && ((op & (op - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/alu_divider.sv
// Iterative unsigned restoring divider, one quotient bit per cycle.
// start loads operands; done pulses one cycle after the last iteration.
module alu_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN + 1);

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] dvs;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // diff[XLEN] set means the trial subtract borrowed
  always_comb begin
    shifted = {remainder, quotient[XLEN-1]};
    diff    = shifted - {1'b0, dvs};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      dvs       <= '0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        busy      <= 1'b1;
        cnt       <= CW'(XLEN);
        dvs       <= divisor;
        quotient  <= dividend;
        remainder <= '0;
      end else if (busy) begin
        quotient  <= {quotient[XLEN-2:0], ~diff[XLEN]};
        remainder <= diff[XLEN] ? shifted[XLEN-1:0]
                                : diff[XLEN-1:0];
        cnt       <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_md_seq.sv
// Registered EX-stage ALU with optional M-extension (ALU_MULDIV_EN).
// Base ops take 1 cycle, MUL* 2, DIV*/REM* XLEN+2; valid/ready both sides.
module alu_md_seq
  import alu_pkg::*;
#(
  parameter  int XLEN    = 32,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [OP_W-1:0] op_i,
  input  logic [XLEN-1:0] op1_i,
  input  logic [XLEN-1:0] op2_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            err_o
);

  md_state_t state, next_state;

  logic               xfer;
  logic               legal;
  logic               load;
  logic               load_err;
  logic [XLEN-1:0]    load_res;
  logic [XLEN-1:0]    base_res;
  logic [SHAMT_W-1:0] shamt;

  assign ready_o = (state == IDLE) && (!valid_o || ready_i) && !flush_i;
  assign xfer    = valid_i && ready_o;
  assign shamt   = op2_i[SHAMT_W-1:0];

`ifdef ALU_MULDIV_EN
  assign legal = one_hot(op_i);
`else
  assign legal = one_hot(op_i) && (|op_i[OP_LUI:0]);
`endif

  always_comb begin
    base_res = '0;
    if (legal) begin
      unique case (1'b1)
        op_i[OP_ADD]:  base_res = op1_i + op2_i;
        op_i[OP_SLL]:  base_res = op1_i << shamt;
        op_i[OP_SLT]:  base_res = {{(XLEN-1){1'b0}},
                                   $signed(op1_i) < $signed(op2_i)};
        op_i[OP_SLTU]: base_res = {{(XLEN-1){1'b0}}, op1_i < op2_i};
        op_i[OP_XOR]:  base_res = op1_i ^ op2_i;
        op_i[OP_SRL]:  base_res = op1_i >> shamt;
        op_i[OP_OR]:   base_res = op1_i | op2_i;
        op_i[OP_AND]:  base_res = op1_i & op2_i;
        op_i[OP_SUB]:  base_res = op1_i - op2_i;
        op_i[OP_SRA]:  base_res = $unsigned($signed(op1_i) >>> shamt);
        op_i[OP_LUI]:  base_res = op1_i;
        default:       base_res = '0;
      endcase
    end
  end

`ifdef ALU_MULDIV_EN
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  logic              is_mul, is_div, div_sgn, rem_op;
  logic              s1, s2, mh_s1, mh_s2;
  logic              div_zero, div_ovf, fast, start;
  logic              div_busy, div_done;
  logic              hi_r, neg_q_r, neg_r_r, rem_r;
  logic [XLEN-1:0]   mag1, mag2, fast_res, quo, rem, div_res;
  logic [2*XLEN-1:0] mprod, prod_r;

  assign is_mul  = |op_i[OP_MULHU:OP_MUL];
  assign is_div  = |op_i[OP_REMU:OP_DIV];
  assign div_sgn = op_i[OP_DIV] | op_i[OP_REM];
  assign rem_op  = op_i[OP_REM] | op_i[OP_REMU];
  assign s1      = div_sgn & op1_i[XLEN-1];
  assign s2      = div_sgn & op2_i[XLEN-1];
  assign mag1    = s1 ? -op1_i : op1_i;
  assign mag2    = s2 ? -op2_i : op2_i;

  assign div_zero = (op2_i == '0);
  assign div_ovf  = div_sgn && (op1_i == MOST_NEG) && (op2_i == '1);
  assign fast     = div_zero || div_ovf;
  // overflow quotient equals the dividend itself (most-negative)
  assign fast_res = div_zero ? (rem_op ? op1_i : '1)
                             : (rem_op ? '0 : op1_i);
  assign start    = xfer && legal && is_div && !fast;

  // sign-extend to 2*XLEN so a plain product gives every signedness mix
  assign mh_s1 = (op_i[OP_MULH] | op_i[OP_MULHSU]) & op1_i[XLEN-1];
  assign mh_s2 = op_i[OP_MULH] & op2_i[XLEN-1];
  assign mprod = {{XLEN{mh_s1}}, op1_i} * {{XLEN{mh_s2}}, op2_i};

  assign div_res = rem_r ? (neg_r_r ? -rem : rem)
                         : (neg_q_r ? -quo : quo);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prod_r  <= '0;
      hi_r    <= 1'b0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
      rem_r   <= 1'b0;
    end else if (xfer) begin
      prod_r  <= mprod;
      hi_r    <= !op_i[OP_MUL];
      neg_q_r <= s1 ^ s2;
      neg_r_r <= s1;
      rem_r   <= rem_op;
    end
  end

  alu_divider #(
    .XLEN(XLEN)
  ) u_div (
    .clk       (clk_i),
    .rst       (rst_i),
    .start     (start),
    .abort     (flush_i),
    .dividend  (mag1),
    .divisor   (mag2),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (quo),
    .remainder (rem)
  );

  always_comb begin
    next_state = state;
    load       = 1'b0;
    load_res   = '0;
    load_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (xfer) begin
          if (!legal) begin
            load     = 1'b1;
            load_err = 1'b1;
          end else if (is_mul) begin
            next_state = MUL;
          end else if (is_div && fast) begin
            load     = 1'b1;
            load_res = fast_res;
          end else if (is_div) begin
            next_state = DIV;
          end else begin
            load     = 1'b1;
            load_res = base_res;
          end
        end
      end
      MUL: begin
        next_state = IDLE;
        load       = 1'b1;
        load_res   = hi_r ? prod_r[2*XLEN-1:XLEN] : prod_r[XLEN-1:0];
      end
      DIV: begin
        if (div_done) begin
          next_state = IDLE;
          load       = 1'b1;
          load_res   = div_res;
        end else if (!div_busy) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    if (flush_i) next_state = IDLE;
  end
`else
  always_comb begin
    next_state = IDLE;
    load       = xfer;
    load_res   = legal ? base_res : '0;
    load_err   = !legal;
  end
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // a held result only clears when consumed or replaced
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      result_o <= '0;
      err_o    <= 1'b0;
    end else if (flush_i) begin
      valid_o <= 1'b0;
    end else if (load) begin
      valid_o  <= 1'b1;
      result_o <= load_res;
      err_o    <= load_err;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_md_seq.sv
// Directed table-driven bench for alu_md_seq (XLEN=32).
// Handles builds with and without ALU_MULDIV_EN.
module tb_alu_md_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic            rdy;
  logic [OP_W-1:0] op;
  logic [XLEN-1:0] a, b;
  logic            flush;
  logic            vout;
  logic            take;
  logic [XLEN-1:0] res;
  logic            err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string           name;
    logic [OP_W-1:0] op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            err;
    int              lat;
  } vec_t;

  vec_t vecs[$];

  alu_md_seq #(.XLEN(XLEN)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .valid_i  (valid),
    .ready_o  (rdy),
    .op_i     (op),
    .op1_i    (a),
    .op2_i    (b),
    .flush_i  (flush),
    .valid_o  (vout),
    .ready_i  (take),
    .result_o (res),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [OP_W-1:0] oh(input int i);
    logic [OP_W-1:0] one;
    one = 1;
    return one << i;
  endfunction

  function automatic void add(input string n, input int idx,
                              input logic [XLEN-1:0] x, y, r,
                              input int lat);
    vec_t v;
    v.name = n; v.op = oh(idx); v.a = x; v.b = y;
    v.res = r; v.err = 1'b0; v.lat = lat;
`ifndef ALU_MULDIV_EN
    if (idx >= OP_MUL) begin
      v.res = '0; v.err = 1'b1; v.lat = 1;
    end
`endif
    vecs.push_back(v);
  endfunction

  task automatic run_op(input vec_t v);
    int   lat;
    logic busy_rdy;
    op = v.op; a = v.a; b = v.b; valid = 1'b1; take = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat = 1;
    busy_rdy = 1'b0;
    while (!vout && lat < 100) begin
      if (rdy) busy_rdy = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("%s res", v.name), 64'(res), 64'(v.res));
    chk($sformatf("%s err", v.name), 64'(err), 64'(v.err));
    chk($sformatf("%s lat", v.name), 64'(lat), 64'(v.lat));
    if (v.lat > 1)
      chk($sformatf("%s busy_ready", v.name), 64'(busy_rdy), 64'(0));
  endtask

  initial begin
    int lim;
    logic seen;
    vec_t ill;

    add("add",    OP_ADD,    32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1);
    add("sub",    OP_SUB,    32'h5,         32'h7,         32'hFFFF_FFFE, 1);
    add("sll",    OP_SLL,    32'h1,         32'h3F,        32'h8000_0000, 1);
    add("slt",    OP_SLT,    32'hFFFF_FFFF, 32'h1,         32'h1,         1);
    add("sltu",   OP_SLTU,   32'hFFFF_FFFF, 32'h1,         32'h0,         1);
    add("xor",    OP_XOR,    32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    add("or",     OP_OR,     32'h0000_0F00, 32'h0000_00F0, 32'h0000_0FF0, 1);
    add("and",    OP_AND,    32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
    add("srl",    OP_SRL,    32'h8000_0000, 32'h4,         32'h0800_0000, 1);
    add("sra",    OP_SRA,    32'h8000_0000, 32'h4,         32'hF800_0000, 1);
    add("lui",    OP_LUI,    32'h1234_5000, 32'h0,         32'h1234_5000, 1);
    add("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         2);
    add("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         2);
    add("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2);
    add("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
    add("div",    OP_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 34);
    add("rem",    OP_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 34);
    add("div_np", OP_DIV,    32'h7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 34);
    add("rem_np", OP_REM,    32'h7,         32'hFFFF_FFFE, 32'h1,         34);
    add("divu",   OP_DIVU,   32'd100,       32'd7,         32'd14,        34);
    add("remu",   OP_REMU,   32'd100,       32'd7,         32'd2,         34);
    add("divu0",  OP_DIVU,   32'h5,         32'h0,         32'hFFFF_FFFF, 1);
    add("remu0",  OP_REMU,   32'h5,         32'h0,         32'h5,         1);
    add("div0",   OP_DIV,    32'h5,         32'h0,         32'hFFFF_FFFF, 1);
    add("divovf", OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    add("removf", OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);
    ill.name = "op_zero"; ill.op = '0; ill.a = 32'h3; ill.b = 32'h4;
    ill.res = '0; ill.err = 1'b1; ill.lat = 1;
    vecs.push_back(ill);

    // reset state
    rst = 1'b1; valid = 1'b0; flush = 1'b0; take = 1'b1;
    op = '0; a = '0; b = '0;
    #12;
    chk("rst valid", 64'(vout), 64'(0));
    chk("rst result", 64'(res), 64'(0));
    chk("rst err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready after rst", 64'(rdy), 64'(1));

    foreach (vecs[i]) run_op(vecs[i]);

    // back-to-back base ops at full throughput
    op = oh(OP_ADD); a = 32'h7FFF_FFFF; b = 32'h1; valid = 1'b1;
    @(posedge clk); #1;
    op = oh(OP_SRA); a = 32'h8000_0000; b = 32'h4;
    chk("b2b add valid", 64'(vout), 64'(1));
    chk("b2b add res", 64'(res), 64'(32'h8000_0000));
    @(posedge clk); #1;
    valid = 1'b0;
    chk("b2b sra valid", 64'(vout), 64'(1));
    chk("b2b sra res", 64'(res), 64'(32'hF800_0000));
    @(posedge clk); #1;

    // illegal op held while downstream stalls; next op must wait
    op = 19'b11; a = 32'h9; b = 32'h9; valid = 1'b1; take = 1'b0;
    @(posedge clk); #1;
    op = oh(OP_ADD); a = 32'h2; b = 32'h3;
    chk("ill valid", 64'(vout), 64'(1));
    chk("ill err", 64'(err), 64'(1));
    chk("ill res", 64'(res), 64'(0));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("hold%0d valid", k), 64'(vout), 64'(1));
      chk($sformatf("hold%0d err", k), 64'(err), 64'(1));
      chk($sformatf("hold%0d res", k), 64'(res), 64'(0));
      chk($sformatf("hold%0d ready", k), 64'(rdy), 64'(0));
    end
    take = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("after hold valid", 64'(vout), 64'(1));
    chk("after hold err", 64'(err), 64'(0));
    chk("after hold res", 64'(res), 64'(5));
    @(posedge clk); #1;

`ifdef ALU_MULDIV_EN
    // flush ten cycles into a divide
    op = oh(OP_DIVU); a = 32'd100; b = 32'd7; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("div busy ready", 64'(rdy), 64'(0));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush ready", 64'(rdy), 64'(1));
    seen = 1'b0;
    lim = 0;
    while (lim < 40) begin
      if (vout) seen = 1'b1;
      @(posedge clk); #1;
      lim++;
    end
    chk("flush no valid", 64'(seen), 64'(0));

    // reset pulse mid-divide
    op = oh(OP_DIV); a = 32'hFFFF_FFF9; b = 32'h2; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("mid div res held", 64'(res), 64'(5));
    #2 rst = 1'b1;
    #1;
    chk("div rst valid", 64'(vout), 64'(0));
    chk("div rst res", 64'(res), 64'(0));
    chk("div rst err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    lim = 0;
    while (lim < 40) begin
      if (vout) seen = 1'b1;
      @(posedge clk); #1;
      lim++;
    end
    chk("div rst no valid", 64'(seen), 64'(0));
`endif

    // reset clears a held result asynchronously
    op = oh(OP_ADD); a = 32'h1; b = 32'h1; valid = 1'b1; take = 1'b0;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("pre rst res", 64'(res), 64'(2));
    #2 rst = 1'b1;
    #1;
    chk("async rst valid", 64'(vout), 64'(0));
    chk("async rst res", 64'(res), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    take = 1'b1;
    @(posedge clk); #1;
    chk("ready after rst2", 64'(rdy), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
